// File: rtl/hci_core_mem_responder.sv
// rtl/hci_core_mem_responder.sv - HCI core-side responder in front of a single-port SRAM
//
// Accepts core requests, forwards them to a single-port SRAM with one cycle of
// read latency and returns load responses in grant order through a small
// response buffer so the core may apply backpressure via lrdy_i.
//
// Ports:
//   clk_i, rst_i                      clock, asynchronous active-high reset
//   req_i, gnt_o                      core request / grant handshake
//   add_i, wen_i, data_i, be_i,       byte address, 1=load 0=store, store data,
//   user_i                            byte enables, user sideband
//   lrdy_i                            core ready for a load response
//   r_data_o, r_valid_o, r_opc_o,     load response data / valid / error flag (0)
//   r_user_o                          and user sideband of the originating load
//   mem_req_o, mem_wen_o, mem_add_o,  SRAM strobe, 1=read 0=write, word address,
//   mem_wdata_o, mem_be_o             write data, byte enables
//   mem_rdata_i                       SRAM read data, one cycle after the strobe

module hci_core_mem_responder #(
    parameter int DW     = 32,
    parameter int AW     = 32,
    parameter int BW     = 8,
    parameter int UW     = 1,
    parameter int MEM_AW = 10,
    parameter int DEPTH  = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_i,
    output logic                 gnt_o,
    input  logic [AW-1:0]        add_i,
    input  logic                 wen_i,
    input  logic [DW-1:0]        data_i,
    input  logic [DW/BW-1:0]     be_i,
    input  logic [UW-1:0]        user_i,
    input  logic                 lrdy_i,
    output logic [DW-1:0]        r_data_o,
    output logic                 r_valid_o,
    output logic                 r_opc_o,
    output logic [UW-1:0]        r_user_o,
    output logic                 mem_req_o,
    output logic                 mem_wen_o,
    output logic [MEM_AW-1:0]    mem_add_o,
    output logic [DW-1:0]        mem_wdata_o,
    output logic [DW/BW-1:0]     mem_be_o,
    input  logic [DW-1:0]        mem_rdata_i
);

    localparam int BEW = DW / BW;
    localparam int OFF = $clog2(BEW);
    localparam int OW  = $clog2(DEPTH + 1);
    localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [OW-1:0] occ;
    logic          inflight;
    logic [UW-1:0] user_q;
    logic [DW-1:0] buf_data [DEPTH];
    logic [UW-1:0] buf_user [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;

    logic          buf_empty;
    logic          pop;
    logic          buf_pop;
    logic          push;
    logic          load_gnt;
    logic [OW:0]   level;

    // Only the word-address slice of add_i reaches the SRAM; the byte offset
    // and any bits above the SRAM range are intentionally dropped.
    logic          unused_add;
    assign unused_add = ^add_i;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign buf_empty = (occ == '0);
    assign pop       = r_valid_o & lrdy_i;
    assign buf_pop   = ~buf_empty & lrdy_i;
    // An inflight response is stored unless it bypasses straight to an accepting core.
    assign push      = inflight & ~(buf_empty & lrdy_i);

    // Slots that will still be held after this cycle's pop; a load is granted
    // only if one more slot is guaranteed for its response.
    assign level    = {1'b0, occ} + (OW+1)'(inflight) - (OW+1)'(pop);
    assign gnt_o    = req_i & (~wen_i | (level < (OW+1)'(DEPTH)));
    assign load_gnt = gnt_o & wen_i;

    assign mem_req_o   = gnt_o;
    assign mem_wen_o   = wen_i;
    assign mem_be_o    = be_i;
    assign mem_wdata_o = data_i;
    assign mem_add_o   = add_i[MEM_AW+OFF-1:OFF];

    assign r_opc_o = 1'b0;

    // Buffered responses are older than the inflight one, so the head wins.
    always_comb begin
        r_valid_o = 1'b0;
        r_data_o  = '0;
        r_user_o  = '0;
        if (!buf_empty) begin
            r_valid_o = 1'b1;
            r_data_o  = buf_data[head];
            r_user_o  = buf_user[head];
        end else if (inflight) begin
            r_valid_o = 1'b1;
            r_data_o  = mem_rdata_i;
            r_user_o  = user_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            occ      <= '0;
            inflight <= 1'b0;
            user_q   <= '0;
            head     <= '0;
            tail     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                buf_data[i] <= '0;
                buf_user[i] <= '0;
            end
        end else begin
            assert (!(push && !buf_pop && occ == OW'(DEPTH)));
            inflight <= load_gnt;
            if (load_gnt) begin
                user_q <= user_i;
            end
            if (push) begin
                buf_data[tail] <= mem_rdata_i;
                buf_user[tail] <= user_q;
                tail           <= ptr_inc(tail);
            end
            if (buf_pop) begin
                head <= ptr_inc(head);
            end
            occ <= occ + OW'(push) - OW'(buf_pop);
        end
    end

endmodule
